// File: rtl/busarbiter.sv
// Two-master round-robin arbiter for the SoC data bus master port.
// Registered grants, bounded ownership (MAXHOLD), 1-cycle tagged read return.
module busarbiter #(
  parameter int WIDTH   = 32,
  parameter int MAXHOLD = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             write0,
  input  logic             write1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] busaddr,
  output logic [WIDTH-1:0] buswdata,
  output logic             buswrite,
  input  logic [WIDTH-1:0] busrdata
);

  localparam int HW = $clog2(MAXHOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic [HW-1:0] holdcnt;
  logic          hold_max;

  assign hold_max = (holdcnt == HW'(MAXHOLD - 1));
  assign gnt0     = (state == OWN0);
  assign gnt1     = (state == OWN1);
  assign rdata    = busrdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      // Owner releases: hand straight to a waiting master, no idle bubble.
      OWN0: begin
        if (!req0)                 state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && hold_max) state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)                 state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && hold_max) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      last    <= 1'b1;
      holdcnt <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == OWN0)      last <= 1'b0;
      else if (state_nxt == OWN1) last <= 1'b1;
      if (state_nxt != state)              holdcnt <= '0;
      else if (state != IDLE && !hold_max) holdcnt <= holdcnt + 1'b1;
      // Return tag tracks the issuing cycle only, so a read survives handoff.
      rvalid0 <= req0 & gnt0 & ~write0;
      rvalid1 <= req1 & gnt1 & ~write1;
    end
  end

  always_comb begin
    busaddr  = '0;
    buswdata = '0;
    buswrite = 1'b0;
    case (state)
      OWN0: begin
        busaddr  = addr0;
        buswdata = wdata0;
        buswrite = write0 & req0;
      end
      OWN1: begin
        busaddr  = addr1;
        buswdata = wdata1;
        buswrite = write1 & req1;
      end
      default: ;
    endcase
  end

endmodule
